// File: rtl/pe_pkg.sv
// Shared constants, FSM state type and signed-saturate helper for the pe_mac_lanes MAC array.
package pe_pkg;

  localparam int LANES_DEF  = 4;
  localparam int DATA_W_DEF = 8;
  localparam int ACC_W_DEF  = 24;
  localparam int CNT_W_DEF  = 8;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ACCUM = 1'b1
  } pe_state_e;

  // Clamp a sign-extended value into the signed range of a w-bit word (w <= 63).
  function automatic logic signed [63:0] sat_signed(input logic signed [63:0] v, input int w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/pe_mac_lane.sv
// One signed MAC lane: product, load-or-accumulate, optional saturation (PE_SAT_EN).
module pe_mac_lane
  import pe_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ACC_W  = ACC_W_DEF
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     en_i,
  input  logic                     first_i,
  input  logic                     clr_i,
  input  logic signed [DATA_W-1:0] ifm_i,
  input  logic signed [DATA_W-1:0] weight_i,
`ifdef PE_SAT_EN
  output logic                     sat_o,
`endif
  output logic signed [ACC_W-1:0]  sum_o
);

  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0]    prod_ext;
  logic signed [ACC_W-1:0]    base;
  logic signed [ACC_W-1:0]    acc_q;

  assign prod     = ifm_i * weight_i;
  assign prod_ext = ACC_W'(prod);
  // The first beat of a window loads the product instead of adding to stale state.
  assign base     = first_i ? '0 : acc_q;

`ifdef PE_SAT_EN
  logic signed [63:0] sum_wide;
  logic signed [63:0] sum_sat;
  logic               sat_q;

  assign sum_wide = 64'(base) + 64'(prod_ext);
  assign sum_sat  = sat_signed(sum_wide, ACC_W);
  assign sum_o    = ACC_W'(sum_sat);
  assign sat_o    = (sum_sat != sum_wide) || (!first_i && sat_q);
`else
  assign sum_o = base + prod_ext;
`endif

  // NOTE: flop state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_q <= '0;
`ifdef PE_SAT_EN
      sat_q <= 1'b0;
`endif
    end else if (en_i) begin
      acc_q <= sum_o;
`ifdef PE_SAT_EN
      sat_q <= sat_o;
`endif
    end else if (clr_i) begin
      acc_q <= '0;
`ifdef PE_SAT_EN
      sat_q <= 1'b0;
`endif
    end
  end

endmodule

// File: rtl/pe_mac_lanes.sv
// Multi-lane windowed MAC with valid/ready I/O and a one-deep output register.
// Optional per-lane saturation and sat_flag output when PE_SAT_EN is defined.
module pe_mac_lanes
  import pe_pkg::*;
#(
  parameter int LANES  = LANES_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int ACC_W  = ACC_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [CNT_W-1:0]        cfg_len,
  input  logic                    clear,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LANES*DATA_W-1:0] ifm,
  input  logic [LANES*DATA_W-1:0] weight,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [LANES*ACC_W-1:0]  ofm,
`ifdef PE_SAT_EN
  output logic [LANES-1:0]        sat_flag,
`endif
  output logic                    busy
);

  pe_state_e               state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [CNT_W-1:0]        len_q, len_d;
  logic [CNT_W-1:0]        eff_len;
  logic                    first_beat, last_beat, accept;
  logic                    out_valid_q, out_valid_d;
  logic [LANES*ACC_W-1:0]  ofm_q, ofm_d;
  logic [LANES*ACC_W-1:0]  lane_sum;
`ifdef PE_SAT_EN
  logic [LANES-1:0]        lane_sat;
  logic [LANES-1:0]        sat_flag_q, sat_flag_d;
`endif

  assign eff_len    = (cfg_len == '0) ? CNT_W'(1) : cfg_len;
  // A clear arriving with a beat restarts the window on that beat.
  assign first_beat = (state_q == ST_IDLE) || clear;
  assign last_beat  = first_beat ? (eff_len == CNT_W'(1)) : (cnt_q == len_q - CNT_W'(1));
  assign in_ready   = !(last_beat && out_valid_q && !out_ready);
  assign accept     = in_valid && in_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // NOTE: every combinational output gets a default first so no path infers a latch.
  always_comb begin
    state_d = state_q;
    if (accept)     state_d = last_beat ? ST_IDLE : ST_ACCUM;
    else if (clear) state_d = ST_IDLE;
  end

  always_comb begin
    busy = (state_q == ST_ACCUM);
  end

  always_comb begin
    cnt_d = cnt_q;
    len_d = len_q;
    if (accept) begin
      if (first_beat) len_d = eff_len;
      if (last_beat)       cnt_d = '0;
      else if (first_beat) cnt_d = CNT_W'(1);
      else                 cnt_d = cnt_q + CNT_W'(1);
    end else if (clear) begin
      cnt_d = '0;
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    ofm_d       = ofm_q;
`ifdef PE_SAT_EN
    sat_flag_d  = sat_flag_q;
`endif
    if (accept && last_beat) begin
      out_valid_d = 1'b1;
      ofm_d       = lane_sum;
`ifdef PE_SAT_EN
      sat_flag_d  = lane_sat;
`endif
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q       <= '0;
      len_q       <= '0;
      out_valid_q <= 1'b0;
      ofm_q       <= '0;
`ifdef PE_SAT_EN
      sat_flag_q  <= '0;
`endif
    end else begin
      cnt_q       <= cnt_d;
      len_q       <= len_d;
      out_valid_q <= out_valid_d;
      ofm_q       <= ofm_d;
`ifdef PE_SAT_EN
      sat_flag_q  <= sat_flag_d;
`endif
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    pe_mac_lane #(
      .DATA_W(DATA_W),
      .ACC_W (ACC_W)
    ) u_lane (
      .clk     (clk),
      .reset_n (reset_n),
      .en_i    (accept),
      .first_i (first_beat),
      .clr_i   (clear),
      .ifm_i   (ifm[i*DATA_W +: DATA_W]),
      .weight_i(weight[i*DATA_W +: DATA_W]),
`ifdef PE_SAT_EN
      .sat_o   (lane_sat[i]),
`endif
      .sum_o   (lane_sum[i*ACC_W +: ACC_W])
    );
  end

  assign out_valid = out_valid_q;
  assign ofm       = ofm_q;
`ifdef PE_SAT_EN
  assign sat_flag  = sat_flag_q;
`endif

endmodule
